serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor: the inverse-operation counterpart of the full-adder datapath.
- Accepts parallel operands `a`, `b` and a borrow-in, then processes one bit per clock, LSB first, through a single full-subtractor cell.
- Returns the parallel difference and borrow-out with a one-cycle done pulse.
- Used as a low-area arithmetic unit and as a self-checking companion to the adder blocks.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend, captured on accepted start
- b  input  WIDTH  subtrahend, captured on accepted start
- bin  input  1  borrow-in, captured on accepted start
- busy  output  1  high while in SHIFT
- done  output  1  one-cycle pulse, high in DONE state
- diff  output  WIDTH  result (a − b − bin) mod 2^WIDTH
- bout  output  1  final borrow: 1 iff a < b + bin (unsigned)

Behaviour:
- Reset is asynchronous, active-low. Reset values:
  - state=IDLE
  - busy=0, done=0
  - diff=0, bout=0
  - internal shift regs, borrow flop and bit counter = 0
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1 at a clock edge: load a_sh←a, b_sh←b, brw←bin, cnt←0; go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, each edge:
  - Take d,bo from full_subtractor(a_sh[0], b_sh[0], brw).
  - res_sh ← {d, res_sh[WIDTH-1:1]}; a_sh, b_sh shift right by 1; brw←bo; cnt←cnt+1.
  - When cnt==WIDTH-1 on that edge: diff←{d, res_sh[WIDTH-1:1]}, bout←bo, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Latency:
  - start accepted at edge k; shift edges k+1..k+WIDTH.
  - done high between edges k+WIDTH and k+WIDTH+1.
  - Next start is accepted earliest at edge k+WIDTH+2, i.e. in IDLE only.
- busy = (state==SHIFT); done = (state==DONE). Both are registered-state decodes, no combinational path from inputs.
- start while in SHIFT or DONE is ignored: no reload, no effect on the result.
- Operand changes after acceptance have no effect.
- diff/bout hold their last result until the next completion. They are not cleared on start.
- Width rules:
  - cnt width is $clog2(WIDTH).
  - The arithmetic is exactly WIDTH-bit modulo; borrow is carried only through the brw flop.
- Reset mid-operation aborts immediately: all state returns to reset values, no done pulse.
- Wrap-around: the result wraps silently. 0 − 0 − 1 gives diff = all-ones, bout=1.

Decomposition:
- Package serial_sub_pkg:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} sub_state_t
  - default WIDTH constant
- Sub-module full_subtractor, combinational, ports a, b, bin, d, bout:
  - d = a^b^bin
  - bout = (~a & b) | (~(a^b) & bin)
- The cell is instantiated once in serial_subtractor and is unit-testable on its own with all 8 input combinations.

Test Plan:
- Reset then idle: rst_n=0 → busy=0, done=0, diff=0, bout=0. Release with start=0 for 5 cycles → outputs unchanged.
- a=100, b=37, bin=0 (WIDTH=8), start pulse → busy high 8 cycles; done pulse in cycle 9 after accept edge; diff=63, bout=0. Check with an assert that {~bout,diff}-equivalent matches a−b−bin.
- Underflow: a=5, b=9, bin=0 → diff=252, bout=1. Then a=0, b=0, bin=1 → diff=255, bout=1. Then a=255, b=255, bin=1 → diff=255, bout=1.
- Busy lockout: a=200, b=1, bin=0 accepted. Drive start=1 with a=0, b=0 every cycle through SHIFT and DONE → first done gives diff=199, bout=0. A second done follows only after a later IDLE accept, with diff=0.
- Reset mid-operation: accept a=50, b=20. Assert rst_n=0 after 3 shift cycles → busy=0 immediately (asynchronous), no done pulse, diff=0. A new run a=50, b=20 then yields diff=30.
- Exhaustive sweep at WIDTH=4: all a, b in 0..15, bin in {0,1}, back-to-back starts → every result matches (a−b−bin) mod 16, bout = (a < b+bin). done count = 512.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// Imported by the top level and the full-subtractor cell.
package serial_sub_pkg;

   // Controller states for the serial datapath
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } sub_state_t;

   // Default operand/result width
   localparam int SUB_WIDTH_DEF = 8;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin.
// Purely combinational; borrow-out set when a < b + bin.
module full_subtractor
   import serial_sub_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic w_axb;

   assign w_axb = a ^ b;
   assign d     = w_axb ^ bin;
   assign bout  = (~a & b) | (~w_axb & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Computes (a - b - bin) mod 2^WIDTH plus final borrow.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = SUB_WIDTH_DEF
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   sub_state_t       r_state;
   sub_state_t       w_nxt;
   logic             w_load;
   logic             w_shift;
   logic             w_last;

   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-2:0] r_res_sh;
   logic             r_brw;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_diff;
   logic             r_bout;

   logic             w_d;
   logic             w_bo;
   logic [WIDTH-1:0] w_res_nxt;

   full_subtractor u_fs (
      .a    (r_a_sh[0]),
      .b    (r_b_sh[0]),
      .bin  (r_brw),
      .d    (w_d),
      .bout (w_bo)
   );

   // Result bits enter at the MSB and walk down toward bit 0
   assign w_res_nxt = {w_d, r_res_sh};
   assign w_last    = (r_cnt == LAST);

   // Controller state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nxt;
      end
   end

   // Next-state and datapath strobes
   always_comb begin
      w_nxt   = r_state;
      w_load  = 1'b0;
      w_shift = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (start) begin
               w_load = 1'b1;
               w_nxt  = SHIFT;
            end
         end
         SHIFT: begin
            w_shift = 1'b1;
            if (w_last) begin
               w_nxt = DONE;
            end
         end
         DONE: begin
            w_nxt = IDLE;
         end
         default: begin
            w_nxt = IDLE;
         end
      endcase
   end

   // Operand capture and per-bit shift of the serial datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_sh   <= '0;
         r_b_sh   <= '0;
         r_res_sh <= '0;
         r_brw    <= 1'b0;
         r_cnt    <= '0;
      end else if (w_load) begin
         r_a_sh <= a;
         r_b_sh <= b;
         r_brw  <= bin;
         r_cnt  <= '0;
      end else if (w_shift) begin
         r_res_sh <= w_res_nxt[WIDTH-1:1];
         r_a_sh   <= r_a_sh >> 1;
         r_b_sh   <= r_b_sh >> 1;
         r_brw    <= w_bo;
         r_cnt    <= r_cnt + CW'(1);
      end
   end

   // Result registers hold until the next completion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_diff <= '0;
         r_bout <= 1'b0;
      end else if (w_shift && w_last) begin
         r_diff <= w_res_nxt;
         r_bout <= w_bo;
      end
   end

   assign busy = (r_state == SHIFT);
   assign done = (r_state == DONE);
   assign diff = r_diff;
   assign bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=4.
// Reference results come from plain integer arithmetic.
module tb_serial_subtractor;

   logic       clk;
   logic       rst_n;

   logic       st8, bi8, busy8, done8, bout8;
   logic [7:0] a8, b8, diff8;

   logic       st4, bi4, busy4, done4, bout4;
   logic [3:0] a4, b4, diff4;

   int n_tot;
   int n_bad;
   int n_done4;

   serial_subtractor #(.WIDTH(8)) u8 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (st8),
      .a     (a8),
      .b     (b8),
      .bin   (bi8),
      .busy  (busy8),
      .done  (done8),
      .diff  (diff8),
      .bout  (bout8)
   );

   serial_subtractor #(.WIDTH(4)) u4 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (st4),
      .a     (a4),
      .b     (b4),
      .bin   (bi4),
      .busy  (busy4),
      .done  (done4),
      .diff  (diff4),
      .bout  (bout4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count done pulses of the narrow instance
   always @(negedge clk) begin
      if (done4 === 1'b1) n_done4++;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Returns {bout, diff} with diff in the low w bits
   function automatic logic [8:0] ref_sub(input int a, input int b,
                                          input int bi, input int w);
      int m;
      int r;
      logic [8:0] v;
      m = 1 << w;
      r = a - b - bi;
      r = ((r % m) + m) % m;
      v = '0;
      v[7:0] = r[7:0];
      v[8] = (a < b + bi);
      return v;
   endfunction

   // Called one step after a rising edge with u8 in IDLE
   task automatic go8(input logic [7:0] a, input logic [7:0] b,
                      input logic bi, input string tag);
      int nb;
      bit seen;
      logic [8:0] e;
      st8 = 1'b1;
      a8 = a;
      b8 = b;
      bi8 = bi;
      @(posedge clk);
      #1;
      st8 = 1'b0;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      bi8 = 1'($urandom);
      nb = 0;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (done8) begin
            seen = 1;
         end else begin
            if (busy8) nb++;
            @(posedge clk);
            #1;
         end
      end
      e = ref_sub(int'(a), int'(b), int'(bi), 8);
      chk({tag, "_seen"}, 32'(seen), 32'd1);
      chk({tag, "_busy"}, 32'(nb), 32'd8);
      chk({tag, "_diff"}, 32'(diff8), 32'(e[7:0]));
      chk({tag, "_bout"}, 32'(bout8), 32'(e[8]));
      @(posedge clk);
      #1;
      chk({tag, "_pulse"}, 32'(done8), 32'd0);
   endtask

   // Narrow instance run, left at the first IDLE sample after done
   task automatic go4(input int a, input int b, input int bi);
      bit seen;
      logic [8:0] e;
      st4 = 1'b1;
      a4 = 4'(a);
      b4 = 4'(b);
      bi4 = 1'(bi);
      @(posedge clk);
      #1;
      st4 = 1'b0;
      seen = 0;
      for (int i = 0; i < 12 && !seen; i++) begin
         if (done4) begin
            seen = 1;
         end else begin
            @(posedge clk);
            #1;
         end
      end
      e = ref_sub(a, b, bi, 4);
      if (!seen) chk("w4_timeout", 32'd0, 32'd1);
      chk("w4_diff", 32'(diff4), 32'(e[3:0]));
      chk("w4_bout", 32'(bout4), 32'(e[8]));
      @(posedge clk);
      #1;
   endtask

   initial begin
      int nd;
      n_tot = 0;
      n_bad = 0;
      n_done4 = 0;
      rst_n = 1'b0;
      st8 = 0; a8 = '0; b8 = '0; bi8 = 0;
      st4 = 0; a4 = '0; b4 = '0; bi4 = 0;
      #2;
      chk("rst_busy", 32'(busy8), 32'd0);
      chk("rst_done", 32'(done8), 32'd0);
      chk("rst_diff", 32'(diff8), 32'd0);
      chk("rst_bout", 32'(bout8), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("idle_busy", 32'(busy8), 32'd0);
      chk("idle_done", 32'(done8), 32'd0);
      chk("idle_diff", 32'(diff8), 32'd0);
      chk("idle_bout", 32'(bout8), 32'd0);

      go8(8'd100, 8'd37, 1'b0, "basic");
      chk("basic_abs", 32'(diff8), 32'd63);
      go8(8'd5, 8'd9, 1'b0, "uf1");
      chk("uf1_abs", 32'(diff8), 32'd252);
      go8(8'd0, 8'd0, 1'b1, "uf2");
      chk("uf2_abs", 32'({bout8, diff8}), 32'h1FF);
      go8(8'd255, 8'd255, 1'b1, "uf3");
      chk("uf3_abs", 32'({bout8, diff8}), 32'h1FF);

      // start held high through SHIFT and DONE must not reload
      st8 = 1'b1;
      a8 = 8'd200;
      b8 = 8'd1;
      bi8 = 1'b0;
      @(posedge clk);
      #1;
      a8 = 8'd0;
      b8 = 8'd0;
      nd = 0;
      for (int i = 0; i < 20 && nd == 0; i++) begin
         if (done8) nd = 1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      chk("lock_seen", 32'(nd), 32'd1);
      chk("lock_diff", 32'(diff8), 32'd199);
      chk("lock_bout", 32'(bout8), 32'd0);
      @(posedge clk);
      #1;
      chk("lock_idle", 32'({busy8, done8}), 32'd0);
      chk("lock_hold", 32'(diff8), 32'd199);
      @(posedge clk);
      #1;
      st8 = 1'b0;
      nd = 0;
      for (int i = 0; i < 20 && nd == 0; i++) begin
         if (done8) nd = 1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      chk("lock2_seen", 32'(nd), 32'd1);
      chk("lock2_diff", 32'(diff8), 32'd0);
      @(posedge clk);
      #1;

      for (int k = 0; k < 40; k++) begin
         go8(8'($urandom), 8'($urandom), 1'($urandom), "rnd");
      end

      for (int x = 0; x < 16; x++) begin
         for (int y = 0; y < 16; y++) begin
            for (int c = 0; c < 2; c++) begin
               go4(x, y, c);
            end
         end
      end
      @(negedge clk);
      chk("sweep_done_cnt", 32'(n_done4), 32'd512);

      // Abort after three shift edges
      st8 = 1'b1;
      a8 = 8'd50;
      b8 = 8'd20;
      bi8 = 1'b0;
      @(posedge clk);
      #1;
      st8 = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy8), 32'd0);
      chk("abort_done", 32'(done8), 32'd0);
      chk("abort_diff", 32'(diff8), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done8) nd++;
      end
      chk("abort_nodone", 32'(nd), 32'd0);
      @(posedge clk);
      #1;
      go8(8'd50, 8'd20, 1'b0, "rerun");
      chk("rerun_abs", 32'(diff8), 32'd30);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
